// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter branch predictor with direct-mapped target table and mispredict check
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   if_pc                         fetch PC to look up
//   pred_taken, pred_target       combinational prediction for if_pc
//   ex_valid, ex_pc, ex_is_br     execute-stage instruction and whether it is a branch/jump
//   ex_taken, ex_target           resolved outcome
//   ex_pred_taken, ex_pred_target prediction carried down the pipe
//   mispredict, redirect_pc       flush request and correct next PC
//   br_count, mp_count            resolved branch and mispredict counters

module branch_predictor #(
    parameter int BUS_WIDTH = 32,
    parameter int IDX_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] if_pc,
    output logic                 pred_taken,
    output logic [BUS_WIDTH-1:0] pred_target,
    input  logic                 ex_valid,
    input  logic [BUS_WIDTH-1:0] ex_pc,
    input  logic                 ex_is_br,
    input  logic                 ex_taken,
    input  logic [BUS_WIDTH-1:0] ex_target,
    input  logic                 ex_pred_taken,
    input  logic [BUS_WIDTH-1:0] ex_pred_target,
    output logic                 mispredict,
    output logic [BUS_WIDTH-1:0] redirect_pc,
    output logic [31:0]          br_count,
    output logic [31:0]          mp_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = BUS_WIDTH - IDX_BITS - 2;

    logic                 tbl_valid  [ENTRIES];
    logic [TAG_W-1:0]     tbl_tag    [ENTRIES];
    logic [BUS_WIDTH-1:0] tbl_target [ENTRIES];
    logic [1:0]           tbl_ctr    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    logic                if_hit;
    logic                ex_hit;

    // Instructions are word aligned, so the low PC bits never select anything.
    logic unused_if_low_bits;
    assign unused_if_low_bits = ^if_pc[1:0];

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[BUS_WIDTH-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[BUS_WIDTH-1:IDX_BITS+2];

    assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    assign pred_taken  = if_hit & tbl_ctr[if_idx][1];
    assign pred_target = pred_taken ? tbl_target[if_idx] : '0;

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (ex_valid) begin
            if (ex_is_br) begin
                mispredict = (ex_taken != ex_pred_taken) |
                             (ex_taken & (ex_target != ex_pred_target));
            end else begin
                // A non-branch that was predicted taken hit an aliased entry.
                mispredict = ex_pred_taken;
            end
            redirect_pc = (ex_is_br & ex_taken) ? ex_target : ex_pc + BUS_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b00;
            end
            br_count <= '0;
            mp_count <= '0;
        end else if (ex_valid) begin
            if (ex_is_br) begin
                br_count <= br_count + 32'd1;
                if (ex_hit) begin
                    if (ex_taken) begin
                        if (tbl_ctr[ex_idx] != 2'b11) begin
                            tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 2'b01;
                        end
                        tbl_target[ex_idx] <= ex_target;
                    end else if (tbl_ctr[ex_idx] != 2'b00) begin
                        tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 2'b01;
                    end
                end else if (ex_taken) begin
                    // Allocate weakly taken so one contrary outcome flips it.
                    tbl_valid[ex_idx]  <= 1'b1;
                    tbl_tag[ex_idx]    <= ex_tag;
                    tbl_target[ex_idx] <= ex_target;
                    tbl_ctr[ex_idx]    <= 2'b10;
                end
            end else if (ex_hit) begin
                tbl_valid[ex_idx] <= 1'b0;
            end
            if (mispredict) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end

endmodule
